// File: rtl/decode_pkg.sv
// Shared types for the decode stage: immediate formats, opcode constants and the
// decoded entry that travels from fetch towards execute.
package decode_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {FMT_NONE, FMT_U, FMT_B, FMT_J, FMT_IS} imm_fmt_t;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_fmt_t        fmt;
    logic            illegal;
  } dec_entry_t;

  function automatic imm_fmt_t fmt_of(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC:                        fmt_of = FMT_U;
      OP_BRANCH:                               fmt_of = FMT_B;
      OP_JAL:                                  fmt_of = FMT_J;
      OP_LOAD, OP_OPIMM, OP_OPIMM32, OP_JALR,
      OP_STORE:                                fmt_of = FMT_IS;
      default:                                 fmt_of = FMT_NONE;
    endcase
  endfunction

  function automatic logic known_op(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_LOAD, OP_OPIMM, OP_OPIMM32,
      OP_JALR, OP_STORE, OP_OP, OP_OP32, OP_SYSTEM, OP_FENCE: known_op = 1'b1;
      default:                                                 known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// Fetch/execute-facing bundle of the decode stage; slave is the decoder side.
interface decode_ctrl_if
  import decode_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [XLEN-1:0]  if_pc;
  logic             if_ready;
  logic             ex_ready;
  logic             flush;
  logic             id_valid;
  logic [31:0]      id_instr;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_imm;
  imm_fmt_t         id_imm_fmt;
  logic             id_illegal;
  logic [CNT_W-1:0] cnt_decoded;
  logic [CNT_W-1:0] cnt_stall;

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, flush,
    output if_ready, id_valid, id_instr, id_pc, id_imm, id_imm_fmt, id_illegal,
           cnt_decoded, cnt_stall
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_ready, flush,
    input  if_ready, id_valid, id_instr, id_pc, id_imm, id_imm_fmt, id_illegal,
           cnt_decoded, cnt_stall
  );
endinterface

// File: rtl/decode_sext.sv
// Immediate sign-extender shared by the decode path; output is meaningless for FMT_NONE.
module decode_sext
  import decode_pkg::*;
(
  input  logic [31:7]     i_instr,
  input  imm_fmt_t        i_mode,
  input  logic            i_store,
  output logic [XLEN-1:0] o_imm
);
  always_comb begin
    o_imm = '0;
    case (i_mode)
      FMT_U:  o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
      FMT_B:  o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_J:  o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
      FMT_IS: o_imm = i_store ? {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]}
                              : {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      default: o_imm = '0;
    endcase
  end
endmodule

// File: rtl/decode_skid.sv
// Two-entry valid/ready skid buffer (OUT + SKID); ready is registered so it never
// depends combinationally on the downstream ready.
module decode_skid
  import decode_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_flush,
  input  logic       i_valid,
  input  dec_entry_t i_data,
  output logic       o_ready,
  output logic       o_valid,
  output dec_entry_t o_data,
  input  logic       i_ready
);
  logic       r_out_valid;
  logic       r_skid_valid;
  logic       r_ready;
  dec_entry_t r_out;
  dec_entry_t r_skid;
  logic       w_accept;
  logic       w_take;

  assign w_accept = i_valid & r_ready;
  assign w_take   = r_out_valid & i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (!r_out_valid || w_take) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= w_accept;
        r_ready      <= !w_accept;
        if (w_accept) r_skid <= i_data;
      end else begin
        r_out_valid <= w_accept;
        r_ready     <= 1'b1;
        if (w_accept) r_out <= i_data;
      end
    end else if (w_accept) begin
      // OUT is stalled: park the new word behind it
      r_skid       <= i_data;
      r_skid_valid <= 1'b1;
      r_ready      <= 1'b0;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out;
endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage sequencer: classifies the incoming opcode, extends the immediate and
// hands decoded entries to EX through a skid buffer, with handshake counters.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int CNT_W = 32
)(
  input  logic                clk,
  input  logic                reset,
  decode_ctrl_if.slave        bus
);
  logic [6:0]       w_op;
  imm_fmt_t         w_fmt;
  logic [XLEN-1:0]  w_sext_imm;
  dec_entry_t       w_in;
  dec_entry_t       w_out;
  logic             w_out_valid;
  logic             w_ready;
  logic [CNT_W-1:0] r_cnt_decoded;
  logic [CNT_W-1:0] r_cnt_stall;

  assign w_op  = bus.if_instr[6:0];
  assign w_fmt = fmt_of(w_op);

  decode_sext u_sext (
    .i_instr (bus.if_instr[31:7]),
    .i_mode  (w_fmt),
    .i_store (w_op == OP_STORE),
    .o_imm   (w_sext_imm)
  );

  always_comb begin
    w_in.instr   = bus.if_instr;
    w_in.pc      = bus.if_pc;
    w_in.fmt     = w_fmt;
    w_in.illegal = !known_op(w_op);
    w_in.imm     = (w_fmt == FMT_NONE) ? '0 : w_sext_imm;
  end

  decode_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.flush),
    .i_valid (bus.if_valid),
    .i_data  (w_in),
    .o_ready (w_ready),
    .o_valid (w_out_valid),
    .o_data  (w_out),
    .i_ready (bus.ex_ready)
  );

  // a take in a flush cycle still counts, so counters ignore flush
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_decoded <= '0;
      r_cnt_stall   <= '0;
    end else begin
      if (w_out_valid && bus.ex_ready)  r_cnt_decoded <= r_cnt_decoded + 1'b1;
      if (w_out_valid && !bus.ex_ready) r_cnt_stall   <= r_cnt_stall + 1'b1;
    end
  end

  assign bus.if_ready    = w_ready;
  assign bus.id_valid    = w_out_valid;
  assign bus.id_instr    = w_out.instr;
  assign bus.id_pc       = w_out.pc;
  assign bus.id_imm      = w_out.imm;
  assign bus.id_imm_fmt  = w_out.fmt;
  assign bus.id_illegal  = w_out.illegal;
  assign bus.cnt_decoded = r_cnt_decoded;
  assign bus.cnt_stall   = r_cnt_stall;
endmodule

// File: tb/tb_decode_ctrl.sv
// Directed vector table plus handshake corner sequences and a randomised queue check.
module tb_decode_ctrl;
  import decode_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[16];
  item_t q[$];

  always #5 clk = ~clk;

  decode_ctrl_if #(.CNT_W(32)) bus ();
  decode_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.if_valid = 1'b0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic offer(input logic [63:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h00500093;
    bus.if_pc = pc;
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 64'd5,                   3'd4, 1'b0}; // addi
    vecs[1]  = '{32'hFE20AE23, 64'hFFFFFFFFFFFFFFFC,    3'd4, 1'b0}; // sw -4
    vecs[2]  = '{32'h123450B7, 64'h0000000012345000,    3'd1, 1'b0}; // lui
    vecs[3]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC,    3'd2, 1'b0}; // beq -4
    vecs[4]  = '{32'h0000006F, 64'd0,                   3'd3, 1'b0}; // jal 0
    vecs[5]  = '{32'h002081B3, 64'd0,                   3'd0, 1'b0}; // add
    vecs[6]  = '{32'h0000007F, 64'd0,                   3'd0, 1'b1};
    vecs[7]  = '{32'hFFF03083, 64'hFFFFFFFFFFFFFFFF,    3'd4, 1'b0}; // ld -1
    vecs[8]  = '{32'h00008067, 64'd0,                   3'd4, 1'b0}; // jalr
    vecs[9]  = '{32'h00001097, 64'h0000000000001000,    3'd1, 1'b0}; // auipc
    vecs[10] = '{32'h0010809B, 64'd1,                   3'd4, 1'b0}; // addiw
    vecs[11] = '{32'h0FF0000F, 64'd0,                   3'd0, 1'b0}; // fence
    vecs[12] = '{32'h00000073, 64'd0,                   3'd0, 1'b0}; // ecall
    vecs[13] = '{32'h008000EF, 64'd8,                   3'd3, 1'b0}; // jal +8
    vecs[14] = '{32'h00209463, 64'd8,                   3'd2, 1'b0}; // bne +8
    vecs[15] = '{32'h00000057, 64'd0,                   3'd0, 1'b1};

    bus.if_instr = '0;
    bus.if_pc = '0;
    do_reset();
    check("rst_id_valid", bus.id_valid, 0);
    check("rst_if_ready", bus.if_ready, 1);
    check("rst_id_pc", bus.id_pc, 0);
    check("rst_id_imm", bus.id_imm, 0);
    check("rst_cnt_decoded", bus.cnt_decoded, 0);
    check("rst_cnt_stall", bus.cnt_stall, 0);

    // streamed table, EX always ready
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.if_valid = 1'b1;
      bus.if_instr = vecs[i].instr;
      bus.if_pc = 64'h80000000 + 64'(i * 4);
      tick();
      check($sformatf("v%0d_valid", i), bus.id_valid, 1);
      check($sformatf("v%0d_instr", i), bus.id_instr, vecs[i].instr);
      check($sformatf("v%0d_pc", i), bus.id_pc, 64'h80000000 + 64'(i * 4));
      check($sformatf("v%0d_imm", i), bus.id_imm, vecs[i].imm);
      check($sformatf("v%0d_fmt", i), bus.id_imm_fmt, vecs[i].fmt);
      check($sformatf("v%0d_ill", i), bus.id_illegal, vecs[i].ill);
    end
    bus.if_valid = 1'b0;
    tick();
    check("stream_drain_valid", bus.id_valid, 0);
    check("stream_cnt_decoded", bus.cnt_decoded, 16);
    check("stream_cnt_stall", bus.cnt_stall, 0);

    // backpressure: A to OUT, B to SKID, C held by fetch
    do_reset();
    offer(64'hA0);
    tick();
    offer(64'hB0);
    tick();
    offer(64'hC0);
    check("bp_out_a", bus.id_pc, 64'hA0);
    check("bp_ready_low", bus.if_ready, 0);
    tick();
    check("bp_hold_a", bus.id_pc, 64'hA0);
    check("bp_ready_still_low", bus.if_ready, 0);
    check("bp_cnt_stall", bus.cnt_stall, 2);
    bus.ex_ready = 1'b1;
    tick();
    check("bp_out_b", bus.id_pc, 64'hB0);
    check("bp_ready_back", bus.if_ready, 1);
    tick();
    bus.if_valid = 1'b0;
    check("bp_out_c", bus.id_pc, 64'hC0);
    check("bp_valid_c", bus.id_valid, 1);
    tick();
    check("bp_empty", bus.id_valid, 0);
    check("bp_cnt_decoded", bus.cnt_decoded, 3);
    check("bp_cnt_stall_final", bus.cnt_stall, 2);

    // flush with both entries full and an instruction arriving
    do_reset();
    offer(64'hA0);
    tick();
    offer(64'hB0);
    tick();
    offer(64'hD0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    check("fl_valid", bus.id_valid, 0);
    check("fl_ready", bus.if_ready, 1);
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_ghost", bus.id_valid, 0);
    end
    check("fl_cnt_decoded", bus.cnt_decoded, 0);

    // flush while EX takes OUT and fetch offers an acceptable word
    do_reset();
    bus.ex_ready = 1'b1;
    offer(64'hE0);
    tick();
    offer(64'hF0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    check("fl2_valid", bus.id_valid, 0);
    check("fl2_take_counted", bus.cnt_decoded, 1);
    check("fl2_ready", bus.if_ready, 1);
    tick();
    check("fl2_no_ghost", bus.id_valid, 0);

    // reset while stalled and full
    do_reset();
    offer(64'hA0);
    tick();
    offer(64'hB0);
    tick();
    check("rs_pre_ready", bus.if_ready, 0);
    check("rs_pre_stall", bus.cnt_stall, 1);
    reset = 1'b1;
    bus.if_valid = 1'b0;
    tick();
    reset = 1'b0;
    check("rs_valid", bus.id_valid, 0);
    check("rs_cnt_stall", bus.cnt_stall, 0);
    check("rs_cnt_decoded", bus.cnt_decoded, 0);
    check("rs_ready", bus.if_ready, 1);
    bus.ex_ready = 1'b1;
    offer(64'h80000000);
    tick();
    bus.if_valid = 1'b0;
    check("rs_first_valid", bus.id_valid, 1);
    check("rs_first_imm", bus.id_imm, 5);
    check("rs_first_fmt", bus.id_imm_fmt, 4);
    check("rs_first_ill", bus.id_illegal, 0);

    // random traffic against a queue model
    do_reset();
    begin
      int n_take = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        logic ev, er, acc, tk;
        int   k;
        check("rnd_id_valid", bus.id_valid, q.size() != 0);
        check("rnd_if_ready", bus.if_ready, q.size() < 2);
        ev = 1'($urandom_range(0, 1));
        er = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 15);
        acc = ev && (q.size() < 2);
        tk = er && (q.size() != 0);
        if (tk) begin
          check("rnd_pc", bus.id_pc, q[0].pc);
          check("rnd_imm", bus.id_imm, q[0].imm);
          void'(q.pop_front());
          n_take++;
        end
        if (acc) q.push_back('{64'h1000 + 64'(cyc * 4), vecs[k].imm});
        bus.if_valid = ev;
        bus.if_instr = vecs[k].instr;
        bus.if_pc = 64'h1000 + 64'(cyc * 4);
        bus.ex_ready = er;
        tick();
      end
      bus.if_valid = 1'b0;
      bus.ex_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (q.size() != 0) begin
          check("drain_pc", bus.id_pc, q[0].pc);
          void'(q.pop_front());
          n_take++;
        end
        tick();
      end
      check("rnd_drained", bus.id_valid, 0);
      check("rnd_cnt_decoded", bus.cnt_decoded, 64'(n_take));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
